// File: rtl/rf_writeback_arbiter.sv
// Register-file writeback arbiter: LSU responses win over queued ALU results (bounded streak),
// tracks outstanding destinations for decode busy checks. Optional cycle trace: RF_WB_TRACE_EN.
module rf_writeback_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] chk_raddr1,
    input  logic [ADDR_WIDTH-1:0] chk_raddr2,
    output logic                  chk_busy1,
    output logic                  chk_busy2,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  iss_err
);
    // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
    // alu_ready depends only on registered occupancy; lsu_ready only on registered streak/occupancy.

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int NREG   = 1 << ADDR_WIDTH;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] fifo_rd_q   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_rd_d   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_vld_q, fifo_vld_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            streak_q, streak_d;
    logic [NREG-1:0]       pend_q, pend_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  src_lsu_q, src_lsu_d;
    logic                  err_q, err_d;

    logic full, empty, push, lsu_gnt, alu_gnt;
    logic [ADDR_WIDTH-1:0] head_rd;
    logic [DATA_WIDTH-1:0] head_data;
    logic fifo_hit1, fifo_hit2;

    assign full      = (cnt_q == DEPTH_C);
    assign empty     = (cnt_q == '0);
    assign alu_ready = ~full;
    // Gated by reset so no load response is consumed while the block is held in reset.
    assign lsu_ready = rst & ~((streak_q == 2'd2) & ~empty);
    assign push      = alu_valid & alu_ready;
    assign lsu_gnt   = lsu_valid & lsu_ready;
    assign alu_gnt   = ~lsu_gnt & ~empty;
    assign head_rd   = fifo_rd_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        fifo_vld_d  = fifo_vld_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = alu_rd;
            fifo_data_d[wr_ptr_q] = alu_data;
            fifo_vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end
        if (alu_gnt) begin
            fifo_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d             = rd_ptr_q + 1'b1;
        end
        case ({push, alu_gnt})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Streak counts LSU wins only while an ALU result is actually waiting.
    always_comb begin
        streak_d = streak_q;
        if (empty || alu_gnt) begin
            streak_d = 2'd0;
        end else if (lsu_gnt) begin
            streak_d = streak_q + 2'd1;
        end
    end

    always_comb begin
        wen_d     = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        src_lsu_d = src_lsu_q;
        if (lsu_gnt) begin
            if (lsu_rd != '0) begin
                wen_d     = 1'b1;
                waddr_d   = lsu_rd;
                wdata_d   = lsu_data;
                src_lsu_d = 1'b1;
            end
        end else if (alu_gnt) begin
            if (head_rd != '0) begin
                wen_d     = 1'b1;
                waddr_d   = head_rd;
                wdata_d   = head_data;
                src_lsu_d = 1'b0;
            end
        end
    end

    // Clear first so a same-cycle issue to the same register keeps the bit set.
    always_comb begin
        pend_d = pend_q;
        err_d  = err_q;
        if (lsu_gnt) begin
            pend_d[lsu_rd] = 1'b0;
        end
        if (iss_valid && iss_rd != '0) begin
            pend_d[iss_rd] = 1'b1;
        end
        if (iss_valid && iss_rd != '0 && pend_q[iss_rd] && !(lsu_gnt && lsu_rd == iss_rd)) begin
            err_d = 1'b1;
        end
        if (lsu_gnt && lsu_rd != '0 && !pend_q[lsu_rd]) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        fifo_hit1 = 1'b0;
        fifo_hit2 = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_vld_q[i] && fifo_rd_q[i] == chk_raddr1) fifo_hit1 = 1'b1;
            if (fifo_vld_q[i] && fifo_rd_q[i] == chk_raddr2) fifo_hit2 = 1'b1;
        end
        chk_busy1 = (chk_raddr1 != '0) &
                    (pend_q[chk_raddr1] | fifo_hit1 | (wen_q & (waddr_q == chk_raddr1)));
        chk_busy2 = (chk_raddr2 != '0) &
                    (pend_q[chk_raddr2] | fifo_hit2 | (wen_q & (waddr_q == chk_raddr2)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            fifo_vld_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            streak_q   <= 2'd0;
            pend_q     <= '0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            src_lsu_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            fifo_vld_q  <= fifo_vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            pend_q      <= pend_d;
            wen_q       <= wen_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            src_lsu_q   <= src_lsu_d;
            err_q       <= err_d;
        end
    end

    assign wen     = wen_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign iss_err = err_q;

`ifdef RF_WB_TRACE_EN
    logic [31:0] trace_cyc_q;
    logic        trace_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trace_cyc_q <= '0;
            trace_err_q <= 1'b0;
        end else begin
            trace_cyc_q <= trace_cyc_q + 32'd1;
            trace_err_q <= err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && wen_q) begin
            $display("rf_wb cyc=%0d waddr=%0d wdata=%h src=%s",
                     trace_cyc_q, waddr_q, wdata_q, src_lsu_q ? "LSU" : "ALU");
        end
        if (rst && err_q && !trace_err_q) begin
            $display("rf_wb cyc=%0d protocol error flagged", trace_cyc_q);
        end
    end
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed self-checking bench for rf_writeback_arbiter: latency, busy tracking,
// fairness, rd=0 handling, sticky protocol error and mid-operation reset.
module tb_rf_writeback_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [3:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        iss_valid;
    logic [3:0]  iss_rd;
    logic [3:0]  chk_raddr1, chk_raddr2;
    logic        chk_busy1, chk_busy2;
    logic        wen;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        iss_err;

    int n_checks = 0;
    int n_fail   = 0;

    rf_writeback_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .chk_raddr1(chk_raddr1), .chk_raddr2(chk_raddr2),
        .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .wen(wen), .waddr(waddr), .wdata(wdata), .iss_err(iss_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        #1;
        check("rst_wen", {31'd0, wen}, 32'd0);
        check("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        check("rst_iss_err", {31'd0, iss_err}, 32'd0);
        tick();
        tick();
        #2;
        rst = 1'b1;
        tick();
    endtask

    initial begin
        idle();
        chk_raddr1 = '0;
        chk_raddr2 = '0;
        rst = 1'b0;
        #1;
        // Reset state
        check("reset_wen", {31'd0, wen}, 32'd0);
        check("reset_waddr", {28'd0, waddr}, 32'd0);
        check("reset_wdata", wdata, 32'd0);
        check("reset_iss_err", {31'd0, iss_err}, 32'd0);
        check("reset_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        tick();
        #2;
        rst = 1'b1;
        tick();
        check("post_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        check("post_rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);

        // ALU single result, rd=5
        chk_raddr1 = 4'd5;
        chk_raddr2 = 4'd0;
        check("alu5_busy_before", {31'd0, chk_busy1}, 32'd0);
        alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 32'h1234_5678;
        tick();
        idle();
        check("alu5_wen_n1", {31'd0, wen}, 32'd0);
        check("alu5_busy_n1", {31'd0, chk_busy1}, 32'd1);
        tick();
        check("alu5_wen_n2", {31'd0, wen}, 32'd1);
        check("alu5_waddr", {28'd0, waddr}, 32'd5);
        check("alu5_wdata", wdata, 32'h1234_5678);
        check("alu5_busy_n2", {31'd0, chk_busy1}, 32'd1);
        tick();
        check("alu5_wen_n3", {31'd0, wen}, 32'd0);
        check("alu5_busy_n3", {31'd0, chk_busy1}, 32'd0);
        check("alu5_waddr_hold", {28'd0, waddr}, 32'd5);

        // Issued load rd=10 then its response
        chk_raddr1 = 4'd10;
        iss_valid = 1'b1; iss_rd = 4'd10;
        check("ld10_busy_before", {31'd0, chk_busy1}, 32'd0);
        tick();
        idle();
        check("ld10_busy_pend", {31'd0, chk_busy1}, 32'd1);
        tick();
        check("ld10_busy_pend2", {31'd0, chk_busy1}, 32'd1);
        lsu_valid = 1'b1; lsu_rd = 4'd10; lsu_data = 32'hDEAD_BEEF;
        check("ld10_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        tick();
        idle();
        check("ld10_wen", {31'd0, wen}, 32'd1);
        check("ld10_waddr", {28'd0, waddr}, 32'd10);
        check("ld10_wdata", wdata, 32'hDEAD_BEEF);
        check("ld10_busy_wr", {31'd0, chk_busy1}, 32'd1);
        check("ld10_err", {31'd0, iss_err}, 32'd0);
        tick();
        check("ld10_busy_after", {31'd0, chk_busy1}, 32'd0);
        check("ld10_wen_after", {31'd0, wen}, 32'd0);

        // ALU result to rd=0 is consumed without a write
        chk_raddr1 = 4'd0;
        alu_valid = 1'b1; alu_rd = 4'd0; alu_data = 32'hFFFF_FFFF;
        check("rd0_alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        idle();
        check("rd0_busy_q", {31'd0, chk_busy1}, 32'd0);
        tick();
        check("rd0_wen_pop", {31'd0, wen}, 32'd0);
        check("rd0_busy_pop", {31'd0, chk_busy1}, 32'd0);
        check("rd0_waddr_hold", {28'd0, waddr}, 32'd10);
        tick();
        check("rd0_wen_after", {31'd0, wen}, 32'd0);
        check("rd0_alu_ready_after", {31'd0, alu_ready}, 32'd1);

        // Double issue to rd=3 is a sticky error
        iss_valid = 1'b1; iss_rd = 4'd3;
        tick();
        check("dbl3_err_first", {31'd0, iss_err}, 32'd0);
        tick();
        idle();
        check("dbl3_err_second", {31'd0, iss_err}, 32'd1);
        tick();
        tick();
        check("dbl3_err_sticky", {31'd0, iss_err}, 32'd1);
        do_reset();
        check("dbl3_err_cleared", {31'd0, iss_err}, 32'd0);

        // Unsolicited load response rd=7
        lsu_valid = 1'b1; lsu_rd = 4'd7; lsu_data = 32'h0000_0777;
        tick();
        idle();
        check("ld7_err", {31'd0, iss_err}, 32'd1);
        check("ld7_wen", {31'd0, wen}, 32'd1);
        check("ld7_waddr", {28'd0, waddr}, 32'd7);

        // Fairness: LSU held continuously while two ALU results queue up
        lsu_valid = 1'b1; lsu_rd = 4'd9; lsu_data = 32'h1000_0001;
        alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 32'hA000_0001;
        tick();
        check("fair_t1_waddr", {28'd0, waddr}, 32'd9);
        check("fair_t1_wdata", wdata, 32'h1000_0001);
        alu_rd = 4'd2; alu_data = 32'hA000_0002; lsu_data = 32'h1000_0002;
        tick();
        alu_valid = 1'b0;
        check("fair_t2_waddr", {28'd0, waddr}, 32'd9);
        check("fair_full_alu_ready", {31'd0, alu_ready}, 32'd0);
        check("fair_t2_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        lsu_data = 32'h1000_0003;
        tick();
        check("fair_t3_wdata", wdata, 32'h1000_0003);
        check("fair_t3_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        lsu_data = 32'h1000_0004;
        tick();
        check("fair_t4_waddr", {28'd0, waddr}, 32'd1);
        check("fair_t4_wdata", wdata, 32'hA000_0001);
        check("fair_t4_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        check("fair_t4_alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        check("fair_t5_wdata", wdata, 32'h1000_0004);
        lsu_data = 32'h1000_0005;
        tick();
        check("fair_t6_wdata", wdata, 32'h1000_0005);
        check("fair_t6_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        tick();
        check("fair_t7_waddr", {28'd0, waddr}, 32'd2);
        check("fair_t7_wdata", wdata, 32'hA000_0002);
        tick();
        check("fair_t8_waddr", {28'd0, waddr}, 32'd9);
        check("fair_t8_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        idle();
        tick();
        tick();

        // Reset with two queued ALU results and pending bit 4
        chk_raddr1 = 4'd4;
        chk_raddr2 = 4'd6;
        iss_valid = 1'b1; iss_rd = 4'd4;
        alu_valid = 1'b1; alu_rd = 4'd6; alu_data = 32'hC000_0006;
        lsu_valid = 1'b1; lsu_rd = 4'd9; lsu_data = 32'h2000_0001;
        tick();
        iss_valid = 1'b0;
        alu_rd = 4'd8; alu_data = 32'hC000_0008; lsu_data = 32'h2000_0002;
        tick();
        idle();
        check("rstq_busy4_before", {31'd0, chk_busy1}, 32'd1);
        check("rstq_busy6_before", {31'd0, chk_busy2}, 32'd1);
        check("rstq_full", {31'd0, alu_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("rstq_wen_now", {31'd0, wen}, 32'd0);
        check("rstq_busy4_now", {31'd0, chk_busy1}, 32'd0);
        check("rstq_busy6_now", {31'd0, chk_busy2}, 32'd0);
        tick();
        #2;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rstq_no_write", {31'd0, wen}, 32'd0);
        end
        check("rstq_busy4_after", {31'd0, chk_busy1}, 32'd0);
        check("rstq_alu_ready", {31'd0, alu_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rf_writeback_arbiter.md
# rf_writeback_arbiter

Arbitrates register-file writebacks between the single-cycle ALU result path and the multi-cycle LSU load-response path, and drives the register file write port (wen/waddr/wdata) from registered outputs. It also tracks which destination registers still have a writeback outstanding and answers busy queries for the decode stage's two read addresses. It sits between the execute/LSU stages and the register file as the writer end of the register file's write interface.

## Interface
- ADDR_WIDTH, 4, register index width (RV32E: 16 registers)
- DATA_WIDTH, 32, register data width
- FIFO_DEPTH, 2, ALU result queue depth (power of two, ≥2)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU queue not full
- alu_rd  in  ADDR_WIDTH  ALU destination
- alu_data  in  DATA_WIDTH  ALU result
- lsu_valid  in  1  load response offered
- lsu_ready  out  1  load response accepted this cycle
- lsu_rd  in  ADDR_WIDTH  load destination
- lsu_data  in  DATA_WIDTH  load data
- iss_valid  in  1  load issued; mark iss_rd pending
- iss_rd  in  ADDR_WIDTH  issued load destination
- chk_raddr1, chk_raddr2  in  ADDR_WIDTH  decode read addresses
- chk_busy1, chk_busy2  out  1  read address has a write outstanding
- wen  out  1  register file write enable
- waddr  out  ADDR_WIDTH  register file write address
- wdata  out  DATA_WIDTH  register file write data
- iss_err  out  1  sticky protocol error

## Operation
- ALU path: every accepted result (alu_valid & alu_ready) pushed into FIFO; alu_ready = ~full, from registered count only.
- LSU path: unbuffered; accepted when lsu_valid & lsu_ready.
- Grant, per cycle: LSU has priority; lsu_ready = ~(streak == 2 & fifo nonempty). If LSU not granted and FIFO nonempty, FIFO head granted and popped.
- Fairness counter streak (0..2): +1 on LSU grant while FIFO nonempty; cleared on ALU grant or when FIFO empty. Max 2 consecutive LSU grants while ALU waits.
- Granted entry registered: next cycle wen=1, waddr=rd, wdata=data. No grant → wen=0, waddr/wdata hold.
- rd = 0: entry consumed normally but wen stays 0.
- Pending mask (2^ADDR_WIDTH bits): iss_valid & iss_rd≠0 sets bit; LSU grant clears bit lsu_rd. Same-cycle set and clear of same bit: set wins.
- chk_busyN = pending[a] | any valid FIFO entry with rd == a | (wen & waddr == a); always 0 for a = 0.
- iss_err set (sticky until reset) on: iss_valid to an already-pending rd≠0 not cleared that cycle; LSU grant with lsu_rd≠0 whose pending bit is 0.
- Push and pop same cycle: count unchanged; allowed only when not full.

## Timing
- Reset (rst low, async): wen=0, waddr=0, wdata=0, FIFO empty, pending=0, streak=0, iss_err=0; lsu_ready=0 while rst low; alu_ready=1 after release.
- LSU latency: lsu_valid at cycle N granted N → wen at N+1.
- ALU latency: push at N → head visible N+1 → wen at N+2 (no LSU conflict).
- Reset mid-operation drops queued results and pending bits; no write issued afterwards.
- Busy outputs combinational from registered state and chk addresses; no dependency on same-cycle handshakes.

## Configuration
- RF_WB_TRACE_EN defined: each cycle with wen=1 issues $display of cycle count, waddr, wdata (hex), and source (ALU/LSU); iss_err rising prints an error line.
- Undefined: no trace logic or output; functional behaviour identical.

## Test plan
- Reset then alu_valid once, rd=5, data=0x12345678 -> wen=1, waddr=5, wdata=0x12345678 two cycles later; chk_busy on 5 high until that write cycle ends.
- iss_valid rd=10, later lsu_valid rd=10 data=0xDEADBEEF -> chk_busy on 10 high from next cycle until write; wen one cycle after grant; pending cleared; iss_err=0.
- Fill FIFO with 2 ALU results while lsu_valid held continuously -> alu_ready=0 when full; exactly 2 LSU grants then ALU grant, pattern repeats until FIFO drains.
- ALU result rd=0 data=0xFFFFFFFF -> alu_ready handshake completes, wen never asserted, chk_busy for addr 0 stays 0.
- iss_valid rd=3 twice without writeback -> iss_err=1, stays 1 until rst low; LSU response rd=7 with no pending -> iss_err=1.
- Assert rst low with 2 queued ALU results and pending bit 4 -> wen=0 immediately, no writes after release, chk_busy on 4 = 0.
